// File: rtl/pat_pkg.sv
// rtl/pat_pkg.sv - shared field/buffer widths and buffer-state encoding for the pat core
package pat_pkg;

    localparam int BUFFER_WIDTH = 8;
    localparam int FIELDP_WIDTH = 5;
    localparam int BUFP_WIDTH   = 3;

    localparam int FIELDS_PER_BUF = 1 << FIELDP_WIDTH;
    localparam int BUF_COUNT      = 1 << BUFP_WIDTH;

    typedef enum logic [1:0] {
        BUF_FREE = 2'd0,
        BUF_FULL = 2'd1,
        BUF_DONE = 2'd2
    } buf_state_t;

endpackage

// File: rtl/pattern_buffer_ram.sv
// rtl/pattern_buffer_ram.sv - field storage with two write ports and two asynchronous read ports
module pattern_buffer_ram #(
    parameter int data_width = 8,
    parameter int addr_width = 8
) (
    input  logic                  clk,
    input  logic                  i_wa_en,
    input  logic [addr_width-1:0] i_wa_addr,
    input  logic [data_width-1:0] i_wa_data,
    input  logic                  i_wb_en,
    input  logic [addr_width-1:0] i_wb_addr,
    input  logic [data_width-1:0] i_wb_data,
    input  logic [addr_width-1:0] i_ra_addr,
    output logic [data_width-1:0] o_ra_data,
    input  logic [addr_width-1:0] i_rb_addr,
    output logic [data_width-1:0] o_rb_data
);

    logic [data_width-1:0] r_mem [0:(1 << addr_width)-1];

    // Both write ports commit at the edge; callers guarantee they hit different buffers.
    always_ff @(posedge clk) begin
        if (i_wa_en) begin
            r_mem[i_wa_addr] <= i_wa_data;
        end
        if (i_wb_en) begin
            r_mem[i_wb_addr] <= i_wb_data;
        end
    end

    // Reads see pre-edge contents, so a same-cycle write returns the old value.
    assign o_ra_data = r_mem[i_ra_addr];
    assign o_rb_data = r_mem[i_rb_addr];

endmodule

// File: rtl/pattern_buffer.sv
// rtl/pattern_buffer.sv - FREE/FULL/DONE field buffer ring between ingress, pat core and egress
module pattern_buffer
    import pat_pkg::*;
#(
    parameter int buffer_width = BUFFER_WIDTH,
    parameter int fieldp_width = FIELDP_WIDTH,
    parameter int bufp_width   = BUFP_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [buffer_width-1:0] in_data,
    input  logic [fieldp_width-1:0] fieldp,
    output logic [buffer_width-1:0] field_in,
    input  logic [fieldp_width-1:0] fieldwp,
    input  logic [buffer_width-1:0] field_out,
    input  logic                    field_we,
    output logic                    proc_valid,
    input  logic                    proc_done,
    output logic [bufp_width-1:0]   bufp,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [buffer_width-1:0] out_data,
    output logic                    out_last
);

    localparam int NBUF = 1 << bufp_width;
    localparam int AW   = bufp_width + fieldp_width;
    localparam logic [fieldp_width-1:0] LAST_IDX = '1;

    buf_state_t                r_state [0:NBUF-1];
    logic [bufp_width-1:0]     r_fill_ptr;
    logic [bufp_width-1:0]     r_proc_ptr;
    logic [bufp_width-1:0]     r_drain_ptr;
    logic [fieldp_width-1:0]   r_fill_idx;
    logic [fieldp_width-1:0]   r_drain_idx;

    logic w_in_ready;
    logic w_proc_valid;
    logic w_out_valid;
    logic w_in_fire;
    logic w_core_we;
    logic w_proc_fire;
    logic w_out_fire;

    assign w_in_ready   = (r_state[r_fill_ptr]  == BUF_FREE);
    assign w_proc_valid = (r_state[r_proc_ptr]  == BUF_FULL);
    assign w_out_valid  = (r_state[r_drain_ptr] == BUF_DONE);

    assign w_in_fire   = in_valid  && w_in_ready;
    assign w_core_we   = field_we  && w_proc_valid;
    assign w_proc_fire = proc_done && w_proc_valid;
    assign w_out_fire  = out_ready && w_out_valid;

    assign in_ready   = w_in_ready;
    assign proc_valid = w_proc_valid;
    assign out_valid  = w_out_valid;
    assign bufp       = r_proc_ptr;
    assign out_last   = w_out_valid && (r_drain_idx == LAST_IDX);

    pattern_buffer_ram #(
        .data_width (buffer_width),
        .addr_width (AW)
    ) u_ram (
        .clk       (clk),
        .i_wa_en   (w_in_fire),
        .i_wa_addr ({r_fill_ptr, r_fill_idx}),
        .i_wa_data (in_data),
        .i_wb_en   (w_core_we),
        .i_wb_addr ({r_proc_ptr, fieldwp}),
        .i_wb_data (field_out),
        .i_ra_addr ({r_proc_ptr, fieldp}),
        .o_ra_data (field_in),
        .i_rb_addr ({r_drain_ptr, r_drain_idx}),
        .o_rb_data (out_data)
    );

    // Advance each role independently; the three roles always own buffers in distinct states.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NBUF; i++) begin
                r_state[i] <= BUF_FREE;
            end
            r_fill_ptr  <= '0;
            r_proc_ptr  <= '0;
            r_drain_ptr <= '0;
            r_fill_idx  <= '0;
            r_drain_idx <= '0;
        end else begin
            if (w_in_fire) begin
                r_fill_idx <= r_fill_idx + 1'b1;
                if (r_fill_idx == LAST_IDX) begin
                    r_state[r_fill_ptr] <= BUF_FULL;
                    r_fill_ptr          <= r_fill_ptr + 1'b1;
                end
            end
            if (w_proc_fire) begin
                r_state[r_proc_ptr] <= BUF_DONE;
                r_proc_ptr          <= r_proc_ptr + 1'b1;
            end
            if (w_out_fire) begin
                r_drain_idx <= r_drain_idx + 1'b1;
                if (r_drain_idx == LAST_IDX) begin
                    r_state[r_drain_ptr] <= BUF_FREE;
                    r_drain_ptr          <= r_drain_ptr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pattern_buffer.sv
// tb/tb_pattern_buffer.sv - self-checking bench for pattern_buffer
module tb_pattern_buffer;
    import pat_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [4:0] fieldp;
    logic [7:0] field_in;
    logic [4:0] fieldwp;
    logic [7:0] field_out;
    logic       field_we;
    logic       proc_valid;
    logic       proc_done;
    logic [2:0] bufp;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    int n_checks = 0;
    int n_errors = 0;

    // reference model of the ring
    logic [7:0] m_mem [8][32];
    logic [1:0] m_state [8];
    logic [2:0] m_fill_ptr, m_proc_ptr, m_drain_ptr;
    logic [4:0] m_fill_idx, m_drain_idx;
    logic [7:0] sb_q [$];

    typedef struct {
        logic       we;
        logic [4:0] wp;
        logic [7:0] wd;
        logic [4:0] rp;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    pattern_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .fieldp     (fieldp),
        .field_in   (field_in),
        .fieldwp    (fieldwp),
        .field_out  (field_out),
        .field_we   (field_we),
        .proc_valid (proc_valid),
        .proc_done  (proc_done),
        .bufp       (bufp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model, then advance model and DUT by one edge.
    task automatic cycle();
        logic e_in_ready, e_proc_valid, e_out_valid, e_out_last;
        #1;
        e_in_ready   = (m_state[m_fill_ptr]  == BUF_FREE);
        e_proc_valid = (m_state[m_proc_ptr]  == BUF_FULL);
        e_out_valid  = (m_state[m_drain_ptr] == BUF_DONE);
        e_out_last   = e_out_valid && (m_drain_idx == 5'd31);
        if (!reset) begin
            chk("in_ready", in_ready, e_in_ready);
            chk("proc_valid", proc_valid, e_proc_valid);
            chk("out_valid", out_valid, e_out_valid);
            chk("out_last", out_last, e_out_last);
            chk("bufp", bufp, m_proc_ptr);
            if (e_proc_valid) chk("field_in", field_in, m_mem[m_proc_ptr][fieldp]);
            if (e_out_valid) begin
                if (sb_q.size() == 0) chk("sb_nonempty", 0, 1);
                else                  chk("out_data", out_data, sb_q[0]);
            end
        end
        if (reset) begin
            for (int i = 0; i < 8; i++) m_state[i] = BUF_FREE;
            m_fill_ptr = 0; m_proc_ptr = 0; m_drain_ptr = 0;
            m_fill_idx = 0; m_drain_idx = 0;
            sb_q.delete();
        end else begin
            if (in_valid && e_in_ready) begin
                m_mem[m_fill_ptr][m_fill_idx] = in_data;
                if (m_fill_idx == 5'd31) begin
                    m_state[m_fill_ptr] = BUF_FULL;
                    m_fill_ptr++;
                end
                m_fill_idx++;
            end
            if (field_we && e_proc_valid) m_mem[m_proc_ptr][fieldwp] = field_out;
            if (proc_done && e_proc_valid) begin
                for (int i = 0; i < 32; i++) sb_q.push_back(m_mem[m_proc_ptr][i]);
                m_state[m_proc_ptr] = BUF_DONE;
                m_proc_ptr++;
            end
            if (out_ready && e_out_valid) begin
                if (sb_q.size() != 0) void'(sb_q.pop_front());
                if (m_drain_idx == 5'd31) begin
                    m_state[m_drain_ptr] = BUF_FREE;
                    m_drain_ptr++;
                end
                m_drain_idx++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n, input logic [7:0] base, input bit rnd);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = rnd ? 8'($urandom) : base + 8'(i);
            cycle();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        repeat (n) cycle();
        out_ready = 1'b0;
    endtask

    task automatic release_buf();
        proc_done = 1'b1;
        cycle();
        proc_done = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 0; in_data = 0; fieldp = 0; fieldwp = 0;
        field_out = 0; field_we = 0; proc_done = 0; out_ready = 0;

        vecs[0] = '{we: 1'b0, wp: 5'd0, wd: 8'h00, rp: 5'd5,  exp_rd: 8'h05};
        vecs[1] = '{we: 1'b0, wp: 5'd0, wd: 8'h00, rp: 5'd0,  exp_rd: 8'h00};
        vecs[2] = '{we: 1'b0, wp: 5'd0, wd: 8'h00, rp: 5'd31, exp_rd: 8'h1F};
        vecs[3] = '{we: 1'b1, wp: 5'd3, wd: 8'hAA, rp: 5'd3,  exp_rd: 8'h03};
        vecs[4] = '{we: 1'b0, wp: 5'd0, wd: 8'h00, rp: 5'd3,  exp_rd: 8'hAA};
        vecs[5] = '{we: 1'b0, wp: 5'd0, wd: 8'h00, rp: 5'd4,  exp_rd: 8'h04};

        cycle();
        cycle();
        reset = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_proc_valid", proc_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_bufp", bufp, 0);

        // first buffer: 00..1F
        fill(31, 8'h00, 0);
        chk("pre_full_proc_valid", proc_valid, 0);
        fill(1, 8'h1F, 0);
        chk("full_proc_valid", proc_valid, 1);
        chk("full_bufp", bufp, 0);

        // core reads and writes from the table
        foreach (vecs[k]) begin
            fieldp = vecs[k].rp; fieldwp = vecs[k].wp;
            field_out = vecs[k].wd; field_we = vecs[k].we;
            #1;
            chk("tbl_field_in", field_in, vecs[k].exp_rd);
            cycle();
        end
        field_we = 1'b0;

        chk("pre_done_out_valid", out_valid, 0);
        release_buf();
        chk("done_out_valid", out_valid, 1);
        chk("done_proc_valid", proc_valid, 0);

        // egress: 00,01,02,AA,04..1F
        drain(31);
        chk("beat32_last", out_last, 1);
        chk("beat32_data", out_data, 8'h1F);
        drain(1);
        chk("drained_out_valid", out_valid, 0);
        chk("drained_in_ready", in_ready, 1);

        // core strobes with no FULL buffer are ignored
        fill(4, 8'h40, 0);
        fieldwp = 5'd3; field_out = 8'h77; field_we = 1'b1; proc_done = 1'b1;
        cycle();
        field_we = 1'b0; proc_done = 1'b0;
        chk("ign_bufp", bufp, 1);
        chk("ign_out_valid", out_valid, 0);
        chk("ign_proc_valid", proc_valid, 0);
        fill(28, 8'h44, 0);
        fieldp = 5'd3;
        #1;
        chk("ign_mem_intact", field_in, 8'h43);

        // fill every remaining buffer: ring full
        for (int b = 0; b < 7; b++) fill(32, 8'h00, 1);
        chk("ring_full_in_ready", in_ready, 0);
        in_valid = 1'b1; in_data = 8'hEE;
        repeat (3) cycle();
        in_valid = 1'b0;
        chk("stall_in_ready", in_ready, 0);
        chk("stall_bufp", bufp, 1);

        // arrange fill idx 31, proc FULL, drain idx 31 on three buffers
        release_buf();
        drain(32);
        fill(31, 8'h60, 0);
        release_buf();
        drain(31);
        in_valid = 1'b1; in_data = 8'h99; proc_done = 1'b1; out_ready = 1'b1;
        #1;
        chk("sim_pre_last", out_last, 1);
        chk("sim_pre_bufp", bufp, 3);
        chk("sim_pre_in_ready", in_ready, 1);
        cycle();
        in_valid = 1'b0; proc_done = 1'b0; out_ready = 1'b0;
        chk("sim_bufp", bufp, 4);
        chk("sim_proc_valid", proc_valid, 1);
        chk("sim_out_valid", out_valid, 1);
        chk("sim_in_ready", in_ready, 1);

        // reset mid-fill (idx 17) and mid-drain
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_data = 8'h80 + 8'(i);
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_proc_valid", proc_valid, 0);
        chk("mid_rst_bufp", bufp, 0);

        fill(32, 8'hC0, 0);
        chk("refill_proc_valid", proc_valid, 1);
        fieldp = 5'd9;
        #1;
        chk("refill_field_in", field_in, 8'hC9);
        release_buf();
        drain(32);
        chk("sb_empty", sb_q.size(), 0);
        chk("final_out_valid", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
